// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two-port round-robin sequencer around a shared 32-bit one-hot-amount left
//   shifter (dout = din << n, s = 1 << n). SLL runs straight through the core.
//   SRL/SRA bit-reverse the operand going in and the result coming out. The
//   SRA sign fill takes a second pass (FILL) that shifts all-ones through the
//   core.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   in_valid0/1, in_ready0/1     request handshake, port 0 = ALU, port 1 = LSU align
//   in_op0/1                     00 SLL, 01 SRL, 11 SRA, 10 reserved (acts as SLL)
//   in_shamt0/1, in_data0/1      shift amount and operand
//   out_valid, out_ready         result handshake
//   out_data, out_id             result and the port that issued it
module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid0,
    output logic        in_ready0,
    input  logic [1:0]  in_op0,
    input  logic [4:0]  in_shamt0,
    input  logic [31:0] in_data0,
    input  logic        in_valid1,
    output logic        in_ready1,
    input  logic [1:0]  in_op1,
    input  logic [4:0]  in_shamt1,
    input  logic [31:0] in_data1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_id
);
    typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [4:0]  shamt_q;
    logic [31:0] data_q;
    logic [31:0] res_q, res_d;
    logic        id_q;
    logic        last_grant_q;
    logic        out_valid_q;

    logic [31:0] core_s, core_din, core_dout;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // A port only loses when the other port is also asking and it won last time.
    assign in_ready0 = !rst && (state_q == IDLE) && in_valid0 &&
                       (!in_valid1 || last_grant_q != 1'b0);
    assign in_ready1 = !rst && (state_q == IDLE) && in_valid1 &&
                       (!in_valid0 || last_grant_q != 1'b1);

    // Core operands: the amount is one-hot only while a pass is in flight.
    always_comb begin
        core_s   = '0;
        core_din = '0;
        case (state_q)
            SHIFT: begin
                core_s   = 32'd1 << shamt_q;
                core_din = op_q[0] ? rev32(data_q) : data_q;
            end
            FILL: begin
                core_s   = 32'd1 << shamt_q;
                core_din = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    // One-hot-amount left shifter.
    always_comb begin
        core_dout = '0;
        for (int i = 0; i < 32; i++)
            if (core_s[i]) core_dout = core_dout | (core_din << i);
    end

    // FILL ORs in ~(ones >> shamt), i.e. the top shamt bits set.
    always_comb begin
        res_d = res_q;
        case (state_q)
            SHIFT:   res_d = op_q[0] ? rev32(core_dout) : core_dout;
            FILL:    res_d = res_q | ~rev32(core_dout);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            shamt_q      <= '0;
            data_q       <= '0;
            res_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            case (state_q)
                IDLE: begin
                    if (in_ready0 || in_ready1) begin
                        id_q         <= in_ready1;
                        last_grant_q <= in_ready1;
                        op_q         <= in_ready1 ? in_op1    : in_op0;
                        shamt_q      <= in_ready1 ? in_shamt1 : in_shamt0;
                        data_q       <= in_ready1 ? in_data1  : in_data0;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (op_q == 2'b11 && data_q[31] && shamt_q != 5'd0) begin
                        state_q <= FILL;
                    end else begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                FILL: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_id    = id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter. Accepted requests push a reference result
// into a scoreboard; each output handshake pops and compares it.
module tb_shift_arbiter;
    logic        clk = 0;
    logic        rst;
    logic        in_valid0, in_valid1, in_ready0, in_ready1;
    logic [1:0]  in_op0, in_op1;
    logic [4:0]  in_shamt0, in_shamt1;
    logic [31:0] in_data0, in_data1;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_data;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   npass = 0;
    int   ntot  = 0;
    int   hs    = 0;
    int   cyc   = 0;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .in_valid0(in_valid0), .in_ready0(in_ready0), .in_op0(in_op0),
        .in_shamt0(in_shamt0), .in_data0(in_data0),
        .in_valid1(in_valid1), .in_ready1(in_ready1), .in_op1(in_op1),
        .in_shamt1(in_shamt1), .in_data1(in_data1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] sh,
                                          input logic [31:0] d);
        case (op)
            2'b01:   return d >> sh;
            2'b11:   return $unsigned($signed(d) >>> sh);
            default: return d << sh;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard push on accept, pop/compare on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready0 && in_ready1) chk("both_ready", 1, 0);
            if (in_valid0 && in_ready0) begin
                sb.push_back('{1'b0, model(in_op0, in_shamt0, in_data0)});
                acc_id.push_back(0); acc_cyc.push_back(cyc);
            end
            if (in_valid1 && in_ready1) begin
                sb.push_back('{1'b1, model(in_op1, in_shamt1, in_data1)});
                acc_id.push_back(1); acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                exp_t e;
                hs++;
                if (sb.size() == 0) chk("spurious_result", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_id", out_id, e.id);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the handshake edge when
    // out_ready is high, otherwise at the negedge where out_valid is first seen.
    task automatic do_req(input bit p, input logic [1:0] op, input logic [4:0] sh,
                          input logic [31:0] d, input int exp_lat, input string tag);
        bit got;
        int lat;
        if (p) begin in_op1 = op; in_shamt1 = sh; in_data1 = d; in_valid1 = 1; end
        else   begin in_op0 = op; in_shamt0 = sh; in_data0 = d; in_valid0 = 1; end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p ? in_ready1 : in_ready0) got = 1;
        end
        chk({tag, "_accept"}, got, 1);
        @(posedge clk); #1;
        in_valid0 = 0; in_valid1 = 0;
        got = 0; lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        rst = 1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int h0;
        logic [31:0] d0;
        rst = 1; in_valid0 = 1; in_valid1 = 1; out_ready = 1;
        in_op0 = 0; in_op1 = 0; in_shamt0 = 0; in_shamt1 = 0; in_data0 = 0; in_data1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", in_ready0, 0);
        chk("rst_ready1", in_ready1, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        @(posedge clk); #1;
        in_valid0 = 0; in_valid1 = 0; rst = 0;
        @(posedge clk); #1;

        // Main function and boundaries.
        do_req(0, 2'b00, 5'd31, 32'h0000_0001, 2, "sll31");
        do_req(1, 2'b11, 5'd4,  32'h8000_0000, 3, "sra_neg4");
        do_req(1, 2'b11, 5'd4,  32'h7000_0000, 2, "sra_pos4");
        do_req(0, 2'b01, 5'd0,  32'hFFFF_FFFF, 2, "srl0");
        do_req(0, 2'b01, 5'd1,  32'hFFFF_FFFF, 2, "srl1");
        do_req(1, 2'b11, 5'd0,  32'h8000_0000, 2, "sra_neg0");
        do_req(0, 2'b11, 5'd31, 32'h8000_0001, 3, "sra_neg31");
        do_req(1, 2'b01, 5'd31, 32'h8000_0000, 2, "srl31");
        do_req(0, 2'b10, 5'd4,  32'h0000_000F, 2, "rsvd");
        do_req(1, 2'b00, 5'd0,  32'hABCD_1234, 2, "sll0");
        do_req(0, 2'b11, 5'd13, 32'hC35A_0F0F, 3, "sra_neg13");
        do_req(1, 2'b01, 5'd7,  32'hDEAD_BEEF, 2, "srl7");

        // Output stall: result and id hold, inputs see backpressure.
        out_ready = 0;
        do_req(1, 2'b00, 5'd8, 32'h0012_3456, 2, "stall");
        d0 = out_data;
        chk("stall_first_data", d0, 32'h1234_5600);
        in_op1 = 0; in_shamt1 = 0; in_data1 = 1; in_valid1 = 1;
        in_op0 = 0; in_shamt0 = 0; in_data0 = 1; in_valid0 = 1;
        h0 = hs;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 32'h1234_5600);
            chk("stall_id", out_id, 1);
            chk("stall_ready0", in_ready0, 0);
            chk("stall_ready1", in_ready1, 0);
        end
        @(posedge clk); #1;
        in_valid0 = 0; in_valid1 = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("stall_release_valid", out_valid, 0);
        chk("stall_one_handshake", hs, h0 + 1);
        @(posedge clk); #1;
        out_ready = 1;

        // Reset while in FILL discards the operation.
        in_op0 = 2'b11; in_shamt0 = 5'd4; in_data0 = 32'h8000_0010; in_valid0 = 1;
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (in_ready0) got = 1;
            end
            chk("fillrst_accept", got, 1);
        end
        @(posedge clk); #1;  // SHIFT
        in_valid0 = 0;
        @(posedge clk); #1;  // FILL
        rst = 1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("fillrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fillrst_no_result", out_valid, 0);
        end
        @(posedge clk); #1;
        do_req(0, 2'b11, 5'd4, 32'h8000_0010, 3, "after_rst");

        // Contention: alternating grants starting at port 0, one every 3 cycles.
        pulse_reset();
        acc_id.delete(); acc_cyc.delete();
        in_op0 = 2'b00; in_shamt0 = 5'd3; in_data0 = 32'h0000_0001; in_valid0 = 1;
        in_op1 = 2'b01; in_shamt1 = 5'd4; in_data1 = 32'h0000_00F0; in_valid1 = 1;
        repeat (18) @(posedge clk);
        #1 in_valid0 = 0; in_valid1 = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("rr_enough_grants", acc_id.size() >= 5, 1);
        for (int i = 0; i < acc_id.size(); i++) begin
            chk("rr_grant_id", acc_id[i], i % 2);
            if (i > 0) chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
